// File: rtl/id_ex_stage_if.sv
// Decode->execute slot bus: decoded fields, pipeline control and bypass sources in; ALU operands out.
// The slave modport is the stage itself, the master modport is the decode/hazard-control side.
interface id_ex_stage_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5,
  parameter int OP_W = 5
);
  logic            in_valid;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic [XLEN-1:0] in_imm;
  logic [RA_W-1:0] in_rs1;
  logic [RA_W-1:0] in_rs2;
  logic [RA_W-1:0] in_rd;
  logic [OP_W-1:0] in_alu_op;
  logic [1:0]      in_a_sel;
  logic            in_b_sel;
  logic            in_reg_write;
  logic            in_mem_read;
  logic            in_is_branch;
  logic            stall;
  logic            flush;
  logic [RA_W-1:0] exm_rd;
  logic            exm_we;
  logic [XLEN-1:0] exm_data;
  logic [RA_W-1:0] mwb_rd;
  logic            mwb_we;
  logic [XLEN-1:0] mwb_data;

  logic            hazard_stall;
  logic            ex_valid;
  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;
  logic [OP_W-1:0] ex_alu_op;
  logic [XLEN-1:0] ex_store_data;
  logic [XLEN-1:0] ex_pc;
  logic [RA_W-1:0] ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_is_branch;

  modport slave (
    input  in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
    input  in_rs1, in_rs2, in_rd, in_alu_op, in_a_sel, in_b_sel,
    input  in_reg_write, in_mem_read, in_is_branch,
    input  stall, flush,
    input  exm_rd, exm_we, exm_data, mwb_rd, mwb_we, mwb_data,
    output hazard_stall, ex_valid, ex_a, ex_b, ex_alu_op, ex_store_data,
    output ex_pc, ex_rd, ex_reg_write, ex_mem_read, ex_is_branch
  );

  modport master (
    output in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
    output in_rs1, in_rs2, in_rd, in_alu_op, in_a_sel, in_b_sel,
    output in_reg_write, in_mem_read, in_is_branch,
    output stall, flush,
    output exm_rd, exm_we, exm_data, mwb_rd, mwb_we, mwb_data,
    input  hazard_stall, ex_valid, ex_a, ex_b, ex_alu_op, ex_store_data,
    input  ex_pc, ex_rd, ex_reg_write, ex_mem_read, ex_is_branch
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand bypass and load-use detection; 1-cycle latency.
// Holds on stall, inserts a bubble on flush or load-use (hazard_stall tells decode to re-present).
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5,
  parameter int OP_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [OP_W-1:0] alu_op;
    logic [1:0]      a_sel;
    logic            b_sel;
    logic            reg_write;
    logic            mem_read;
    logic            is_branch;
  } slot_t;

  slot_t           slot_q, slot_d;
  slot_t           in_slot, bubble;
  logic            hazard;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  function automatic logic [XLEN-1:0] bypass(
    input logic [RA_W-1:0] src,
    input logic [XLEN-1:0] reg_val,
    input logic            exm_we,
    input logic [RA_W-1:0] exm_rd,
    input logic [XLEN-1:0] exm_data,
    input logic            mwb_we,
    input logic [RA_W-1:0] mwb_rd,
    input logic [XLEN-1:0] mwb_data
  );
    logic [XLEN-1:0] val;
    val = reg_val;
    // x0 is hard-wired, so a write to it in flight must never shadow the regfile zero
    if (src != '0) begin
      if (exm_we && (exm_rd == src)) begin
        val = exm_data;
      end else if (mwb_we && (mwb_rd == src)) begin
        val = mwb_data;
      end
    end
    return val;
  endfunction

  always_comb begin
    in_slot           = '0;
    in_slot.valid     = bus.in_valid;
    in_slot.pc        = bus.in_pc;
    in_slot.rs1_data  = bus.in_rs1_data;
    in_slot.rs2_data  = bus.in_rs2_data;
    in_slot.imm       = bus.in_imm;
    in_slot.rs1       = bus.in_rs1;
    in_slot.rs2       = bus.in_rs2;
    in_slot.rd        = bus.in_rd;
    in_slot.alu_op    = bus.in_alu_op;
    in_slot.a_sel     = bus.in_a_sel;
    in_slot.b_sel     = bus.in_b_sel;
    in_slot.reg_write = bus.in_reg_write & bus.in_valid;
    in_slot.mem_read  = bus.in_mem_read  & bus.in_valid;
    in_slot.is_branch = bus.in_is_branch & bus.in_valid;
  end

  // A bubble keeps the operand fields so the ALU inputs stay quiet; only valid/controls/op clear
  always_comb begin
    bubble           = slot_q;
    bubble.valid     = 1'b0;
    bubble.alu_op    = '0;
    bubble.reg_write = 1'b0;
    bubble.mem_read  = 1'b0;
    bubble.is_branch = 1'b0;
  end

  always_comb begin
    hazard = 1'b0;
    if (!bus.flush && slot_q.valid && slot_q.mem_read && (slot_q.rd != '0) && bus.in_valid) begin
      hazard = ((bus.in_rs1 == slot_q.rd) && (bus.in_a_sel == 2'b00)) ||
               (bus.in_rs2 == slot_q.rd);
    end
  end

  always_comb begin
    slot_d = in_slot;
    if (bus.flush) begin
      slot_d = bubble;
    end else if (bus.stall) begin
      slot_d = slot_q;
    end else if (hazard) begin
      slot_d = bubble;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  always_comb begin
    fwd_rs1 = bypass(slot_q.rs1, slot_q.rs1_data, bus.exm_we, bus.exm_rd, bus.exm_data,
                     bus.mwb_we, bus.mwb_rd, bus.mwb_data);
    fwd_rs2 = bypass(slot_q.rs2, slot_q.rs2_data, bus.exm_we, bus.exm_rd, bus.exm_data,
                     bus.mwb_we, bus.mwb_rd, bus.mwb_data);
  end

  always_comb begin
    bus.ex_a = '0;
    case (slot_q.a_sel)
      2'b00:   bus.ex_a = fwd_rs1;
      2'b01:   bus.ex_a = slot_q.pc;
      2'b10:   bus.ex_a = slot_q.imm;
      default: bus.ex_a = '0;
    endcase
  end

  assign bus.ex_b          = slot_q.b_sel ? slot_q.imm : fwd_rs2;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.hazard_stall  = hazard;
  assign bus.ex_valid      = slot_q.valid;
  assign bus.ex_alu_op     = slot_q.alu_op;
  assign bus.ex_pc         = slot_q.pc;
  assign bus.ex_rd         = slot_q.rd;
  assign bus.ex_reg_write  = slot_q.reg_write & slot_q.valid;
  assign bus.ex_mem_read   = slot_q.mem_read  & slot_q.valid;
  assign bus.ex_is_branch  = slot_q.is_branch & slot_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding priority, load-use, stall/flush, operand selects.
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int RA_W = 5;
  localparam int OP_W = 5;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(XLEN), .RA_W(RA_W), .OP_W(OP_W)) bus();

  id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W), .OP_W(OP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clear_in;
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_rs1_data = '0; bus.in_rs2_data = '0;
    bus.in_imm = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0; bus.in_alu_op = '0;
    bus.in_a_sel = '0; bus.in_b_sel = 1'b0; bus.in_reg_write = 1'b0; bus.in_mem_read = 1'b0;
    bus.in_is_branch = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.exm_rd = '0; bus.exm_we = 1'b0; bus.exm_data = '0;
    bus.mwb_rd = '0; bus.mwb_we = 1'b0; bus.mwb_data = '0;
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [4:0] op, input logic [1:0] a_sel,
                           input logic b_sel, input logic rw, input logic mr, input logic br);
    bus.in_valid = 1'b1; bus.in_pc = pc; bus.in_rs1_data = d1; bus.in_rs2_data = d2;
    bus.in_imm = imm; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd; bus.in_alu_op = op;
    bus.in_a_sel = a_sel; bus.in_b_sel = b_sel; bus.in_reg_write = rw;
    bus.in_mem_read = mr; bus.in_is_branch = br;
  endtask

  initial begin
    // reset with garbage on every input
    rst = 1'b1;
    bus.in_valid = 1'($urandom); bus.in_pc = $urandom; bus.in_rs1_data = $urandom;
    bus.in_rs2_data = $urandom; bus.in_imm = $urandom; bus.in_rs1 = 5'($urandom);
    bus.in_rs2 = 5'($urandom); bus.in_rd = 5'($urandom); bus.in_alu_op = 5'($urandom);
    bus.in_a_sel = 2'($urandom); bus.in_b_sel = 1'($urandom); bus.in_reg_write = 1'($urandom);
    bus.in_mem_read = 1'($urandom); bus.in_is_branch = 1'($urandom);
    bus.stall = 1'($urandom); bus.flush = 1'($urandom);
    bus.exm_rd = 5'($urandom); bus.exm_we = 1'b0; bus.exm_data = $urandom;
    bus.mwb_rd = 5'($urandom); bus.mwb_we = 1'b0; bus.mwb_data = $urandom;
    tick;
    tick;
    chk("rst_valid",  32'(bus.ex_valid), 32'd0);
    chk("rst_a",      bus.ex_a, 32'd0);
    chk("rst_b",      bus.ex_b, 32'd0);
    chk("rst_op",     32'(bus.ex_alu_op), 32'd0);
    chk("rst_rw",     32'(bus.ex_reg_write), 32'd0);
    chk("rst_mr",     32'(bus.ex_mem_read), 32'd0);
    chk("rst_br",     32'(bus.ex_is_branch), 32'd0);
    chk("rst_hazard", 32'(bus.hazard_stall), 32'd0);
    chk("rst_pc",     bus.ex_pc, 32'd0);

    rst = 1'b0;
    clear_in;

    // ADD x3 = x1 + x2
    set_instr(32'h0, 32'd5, 32'd7, 32'h0, 5'd1, 5'd2, 5'd3, 5'b00000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick;
    chk("add_valid", 32'(bus.ex_valid), 32'd1);
    chk("add_a",     bus.ex_a, 32'd5);
    chk("add_b",     bus.ex_b, 32'd7);
    chk("add_rd",    32'(bus.ex_rd), 32'd3);
    chk("add_rw",    32'(bus.ex_reg_write), 32'd1);

    // forwarding priority EX/MEM over MEM/WB over regfile
    set_instr(32'h0, 32'h11, 32'h22, 32'h0, 5'd4, 5'd4, 5'd8, 5'b00000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.exm_we = 1'b1; bus.exm_rd = 5'd4; bus.exm_data = 32'hAA;
    bus.mwb_we = 1'b1; bus.mwb_rd = 5'd4; bus.mwb_data = 32'hBB;
    tick;
    chk("fwd_exm_a",  bus.ex_a, 32'hAA);
    chk("fwd_exm_b",  bus.ex_b, 32'hAA);
    chk("fwd_exm_sd", bus.ex_store_data, 32'hAA);
    bus.exm_we = 1'b0;
    settle;
    chk("fwd_mwb_a", bus.ex_a, 32'hBB);
    chk("fwd_mwb_b", bus.ex_b, 32'hBB);
    bus.mwb_we = 1'b0;
    settle;
    chk("fwd_none_a", bus.ex_a, 32'h11);
    chk("fwd_none_sd", bus.ex_store_data, 32'h22);
    set_instr(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd8, 5'b00000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.exm_we = 1'b1; bus.exm_rd = 5'd0; bus.exm_data = 32'hAA;
    bus.mwb_we = 1'b1; bus.mwb_rd = 5'd0; bus.mwb_data = 32'hBB;
    tick;
    chk("fwd_x0_a", bus.ex_a, 32'h0);
    chk("fwd_x0_b", bus.ex_b, 32'h0);
    clear_in;

    // load-use on rs2
    set_instr(32'h20, 32'h0, 32'h0, 32'h8, 5'd1, 5'd2, 5'd5, 5'b00000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    tick;
    chk("ld_mr", 32'(bus.ex_mem_read), 32'd1);
    set_instr(32'h24, 32'h1, 32'h2, 32'h0, 5'd1, 5'd5, 5'd7, 5'b00000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    settle;
    chk("lu_rs2_hazard", 32'(bus.hazard_stall), 32'd1);
    tick;
    chk("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
    chk("lu_bubble_rw",    32'(bus.ex_reg_write), 32'd0);
    chk("lu_hazard_drop",  32'(bus.hazard_stall), 32'd0);
    tick;
    chk("lu_replay_valid", 32'(bus.ex_valid), 32'd1);
    chk("lu_replay_rd",    32'(bus.ex_rd), 32'd7);
    chk("lu_replay_pc",    bus.ex_pc, 32'h24);

    set_instr(32'h28, 32'h0, 32'h0, 32'h8, 5'd1, 5'd2, 5'd5, 5'b00000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    tick;
    set_instr(32'h2C, 32'h1, 32'h2, 32'h0, 5'd0, 5'd6, 5'd7, 5'b00000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    settle;
    chk("lu_nomatch", 32'(bus.hazard_stall), 32'd0);
    bus.in_rs1 = 5'd5;
    settle;
    chk("lu_rs1_hazard", 32'(bus.hazard_stall), 32'd1);
    bus.flush = 1'b1;
    settle;
    chk("lu_flush_mask", 32'(bus.hazard_stall), 32'd0);
    tick;
    chk("flush_valid", 32'(bus.ex_valid), 32'd0);
    bus.flush = 1'b0;

    // stall holds, stall+flush bubbles
    set_instr(32'h40, 32'd3, 32'd4, 32'h0, 5'd1, 5'd2, 5'd9, 5'd3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick;
    chk("pre_stall_a", bus.ex_a, 32'd3);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(32'h44 + 32'(i) * 32'd4, $urandom, $urandom, $urandom, 5'd10, 5'd11, 5'd12,
                5'd7, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
      tick;
      chk("stall_pc", bus.ex_pc, 32'h40);
      chk("stall_a",  bus.ex_a, 32'd3);
      chk("stall_b",  bus.ex_b, 32'd4);
      chk("stall_op", 32'(bus.ex_alu_op), 32'd3);
      chk("stall_valid", 32'(bus.ex_valid), 32'd1);
    end
    bus.flush = 1'b1;
    tick;
    chk("stflush_valid", 32'(bus.ex_valid), 32'd0);
    chk("stflush_rw",    32'(bus.ex_reg_write), 32'd0);
    chk("stflush_op",    32'(bus.ex_alu_op), 32'd0);
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    // operand selects: LUI, AUIPC, zero
    set_instr(32'h200, 32'h0, 32'h0, 32'h12345000, 5'd0, 5'd0, 5'd1, 5'b01010, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    tick;
    chk("lui_a",  bus.ex_a, 32'h12345000);
    chk("lui_op", 32'(bus.ex_alu_op), 32'h0A);
    set_instr(32'h100, 32'h55, 32'h66, 32'h1000, 5'd1, 5'd2, 5'd1, 5'b00000, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    tick;
    chk("auipc_a", bus.ex_a, 32'h100);
    chk("auipc_b", bus.ex_b, 32'h1000);
    chk("auipc_sd", bus.ex_store_data, 32'h66);
    bus.in_a_sel = 2'b11;
    tick;
    chk("zero_a", bus.ex_a, 32'h0);

    // reset mid-stall
    set_instr(32'h300, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd3, 5'd4, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick;
    chk("br_set", 32'(bus.ex_is_branch), 32'd1);
    bus.stall = 1'b1;
    rst = 1'b1;
    tick;
    chk("rst_stall_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_stall_br",    32'(bus.ex_is_branch), 32'd0);
    rst = 1'b0;
    bus.stall = 1'b0;

    // reset mid-hazard
    set_instr(32'h400, 32'h0, 32'h0, 32'h4, 5'd1, 5'd2, 5'd5, 5'b00000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
    tick;
    set_instr(32'h404, 32'h0, 32'h0, 32'h0, 5'd5, 5'd6, 5'd7, 5'b00000, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
    settle;
    chk("lu_rs1_pc_sel", 32'(bus.hazard_stall), 32'd0);
    bus.in_a_sel = 2'b00;
    settle;
    chk("lu_rs1_again", 32'(bus.hazard_stall), 32'd1);
    rst = 1'b1;
    tick;
    chk("rst_hz_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_hz_drop",  32'(bus.hazard_stall), 32'd0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
